dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory port.
// Illegal/misaligned requests are answered with an error and never reach the memory.

module dmem_req_check (
   input  logic [1:0] addr_lo,
   input  logic [2:0] op,
   input  logic       we,
   output logic       illegal
);
   always_comb begin
      illegal = 1'b0;
      case (op)
         3'd0:    illegal = 1'b0;
         3'd1:    illegal = addr_lo[0];
         3'd2:    illegal = (addr_lo != 2'b00);
         3'd4:    illegal = we;
         3'd5:    illegal = we | addr_lo[0];
         default: illegal = 1'b1;
      endcase
   end
endmodule

module dmem_arbiter #(
   parameter int addrWidth = 32,
   parameter int dataWidth = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [1:0]           reqValid,
   output logic [1:0]           reqReady,
   input  logic [addrWidth-1:0] reqAddr0,
   input  logic [addrWidth-1:0] reqAddr1,
   input  logic [dataWidth-1:0] reqWdata0,
   input  logic [dataWidth-1:0] reqWdata1,
   input  logic [2:0]           reqOp0,
   input  logic [2:0]           reqOp1,
   input  logic [1:0]           reqWe,
   output logic [1:0]           respValid,
   output logic [dataWidth-1:0] respRdata,
   output logic                 respErr,
   output logic [addrWidth-1:0] memAddr,
   output logic [dataWidth-1:0] memDin,
   output logic [2:0]           memOp,
   output logic                 memWe,
   input  logic [dataWidth-1:0] memDout
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic [addrWidth-1:0] addr;
      logic [dataWidth-1:0] wdata;
      logic [2:0]           op;
      logic                 we;
   } req_t;

   state_t state;
   logic   last_gnt;
   logic   lat_port;
   logic   lat_we;

   logic [1:0][addrWidth-1:0] port_addr;
   logic [1:0][dataWidth-1:0] port_wdata;
   logic [1:0][2:0]           port_op;
   logic [1:0]                port_ill;

   assign port_addr  = {reqAddr1, reqAddr0};
   assign port_wdata = {reqWdata1, reqWdata0};
   assign port_op    = {reqOp1, reqOp0};

   for (genvar p = 0; p < 2; p++) begin : g_chk
      dmem_req_check u_chk (
         .addr_lo (port_addr[p][1:0]),
         .op      (port_op[p]),
         .we      (reqWe[p]),
         .illegal (port_ill[p])
      );
   end

   // Under contention the port that did not win last time goes first.
   logic win;
   logic any_req;
   logic grant_ok;
   req_t win_req;

   always_comb begin
      win = reqValid[1];
      if (reqValid == 2'b11) win = ~last_gnt;
   end

   assign any_req  = |reqValid;
   assign grant_ok = rstn && (state == IDLE) && any_req;
   assign reqReady = {grant_ok & win, grant_ok & ~win};

   assign win_req.addr  = port_addr[win];
   assign win_req.wdata = port_wdata[win];
   assign win_req.op    = port_op[win];
   assign win_req.we    = reqWe[win];

   // Memory read data arrives in RESP, so loads forward it combinationally.
   assign respRdata = (state == RESP && !respErr && !lat_we) ? memDout : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         lat_port  <= 1'b0;
         lat_we    <= 1'b0;
         memAddr   <= '0;
         memDin    <= '0;
         memOp     <= 3'd2;
         memWe     <= 1'b0;
         respValid <= 2'b00;
         respErr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               respValid <= 2'b00;
               respErr   <= 1'b0;
               if (any_req) begin
                  last_gnt <= win;
                  lat_port <= win;
                  lat_we   <= win_req.we;
                  memAddr  <= win_req.addr;
                  memDin   <= win_req.wdata;
                  memOp    <= win_req.op;
                  if (port_ill[win]) begin
                     state     <= RESP;
                     respValid <= {win, ~win};
                     respErr   <= 1'b1;
                  end else begin
                     state <= ACCESS;
                     memWe <= win_req.we;
                  end
               end
            end
            ACCESS: begin
               memWe     <= 1'b0;
               state     <= RESP;
               respValid <= {lat_port, ~lat_port};
               respErr   <= 1'b0;
            end
            RESP: begin
               respValid <= 2'b00;
               respErr   <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               memWe <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter: single-port table plus contention and reset-abort sequences.

module tb_dmem_arbiter;
   logic        clk;
   logic        rstn;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [31:0] reqAddr0, reqAddr1, reqWdata0, reqWdata1;
   logic [2:0]  reqOp0, reqOp1;
   logic [1:0]  reqWe;
   logic [1:0]  respValid;
   logic [31:0] respRdata;
   logic        respErr;
   logic [31:0] memAddr, memDin, memDout;
   logic [2:0]  memOp;
   logic        memWe;

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .clk(clk), .rstn(rstn), .reqValid(reqValid), .reqReady(reqReady),
      .reqAddr0(reqAddr0), .reqAddr1(reqAddr1), .reqWdata0(reqWdata0), .reqWdata1(reqWdata1),
      .reqOp0(reqOp0), .reqOp1(reqOp1), .reqWe(reqWe), .respValid(respValid),
      .respRdata(respRdata), .respErr(respErr), .memAddr(memAddr), .memDin(memDin),
      .memOp(memOp), .memWe(memWe), .memDout(memDout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  op;
      logic        we;
      logic [31:0] mem;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Entered just after a negedge with the DUT in IDLE; returns the same way.
   task automatic run_vec(input int idx, input vec_t v);
      logic [1:0] oh;
      oh = v.port ? 2'b10 : 2'b01;
      memDout = v.mem;
      reqWe   = v.port ? {v.we, 1'b0} : {1'b0, v.we};
      if (v.port) begin
         reqAddr1 = v.addr; reqWdata1 = v.wdata; reqOp1 = v.op;
      end else begin
         reqAddr0 = v.addr; reqWdata0 = v.wdata; reqOp0 = v.op;
      end
      reqValid = oh;
      #1 chk($sformatf("v%0d reqReady", idx), 32'(reqReady), 32'(oh));
      @(negedge clk);
      reqValid = 2'b00;
      #1;
      if (v.err) begin
         chk($sformatf("v%0d err respValid", idx), 32'(respValid), 32'(oh));
         chk($sformatf("v%0d err respErr", idx), 32'(respErr), 32'd1);
         chk($sformatf("v%0d err respRdata", idx), respRdata, 32'd0);
         chk($sformatf("v%0d err memWe", idx), 32'(memWe), 32'd0);
         @(negedge clk);
         #1 chk($sformatf("v%0d err idle respValid", idx), 32'(respValid), 32'd0);
         chk($sformatf("v%0d err idle memWe", idx), 32'(memWe), 32'd0);
      end else begin
         chk($sformatf("v%0d access memWe", idx), 32'(memWe), 32'(v.we));
         chk($sformatf("v%0d access memAddr", idx), memAddr, v.addr);
         chk($sformatf("v%0d access memOp", idx), 32'(memOp), 32'(v.op));
         chk($sformatf("v%0d access memDin", idx), memDin, v.wdata);
         chk($sformatf("v%0d access respValid", idx), 32'(respValid), 32'd0);
         @(negedge clk);
         #1 chk($sformatf("v%0d resp respValid", idx), 32'(respValid), 32'(oh));
         chk($sformatf("v%0d resp respErr", idx), 32'(respErr), 32'd0);
         chk($sformatf("v%0d resp respRdata", idx), respRdata, v.rdata);
         chk($sformatf("v%0d resp memWe", idx), 32'(memWe), 32'd0);
         chk($sformatf("v%0d resp memAddr", idx), memAddr, v.addr);
         @(negedge clk);
      end
   endtask

   initial begin
      //           port  addr        wdata         op    we    mem            err   rdata
      vecs[0]  = '{1'b0, 32'h100, 32'h0,        3'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 32'h203, 32'hA5,       3'd0, 1'b1, 32'h12345678, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 32'h102, 32'h0,        3'd2, 1'b0, 32'h55555555, 1'b1, 32'h0};
      vecs[3]  = '{1'b0, 32'h100, 32'h0,        3'd6, 1'b0, 32'h55555555, 1'b1, 32'h0};
      vecs[4]  = '{1'b1, 32'h101, 32'h0,        3'd5, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 32'h102, 32'h0,        3'd5, 1'b0, 32'h0000BEEF, 1'b0, 32'h0000BEEF};
      vecs[6]  = '{1'b0, 32'h100, 32'h7,        3'd4, 1'b1, 32'h0,        1'b1, 32'h0};
      vecs[7]  = '{1'b0, 32'h003, 32'h0,        3'd0, 1'b0, 32'hFFFFFF80, 1'b0, 32'hFFFFFF80};
      vecs[8]  = '{1'b1, 32'h100, 32'h0,        3'd3, 1'b0, 32'h1,        1'b1, 32'h0};
      vecs[9]  = '{1'b0, 32'h104, 32'hCAFEF00D, 3'd2, 1'b1, 32'h9,        1'b0, 32'h0};
      vecs[10] = '{1'b1, 32'h001, 32'h1234,     3'd1, 1'b1, 32'h0,        1'b1, 32'h0};

      rstn = 1'b0; reqValid = 2'b00; reqWe = 2'b00;
      reqAddr0 = '0; reqAddr1 = '0; reqWdata0 = '0; reqWdata1 = '0;
      reqOp0 = 3'd2; reqOp1 = 3'd2; memDout = 32'hAAAA5555;

      // Reset values, with both ports already requesting.
      reqAddr0 = 32'h10; reqAddr1 = 32'h20;
      reqValid = 2'b11;
      #12;
      chk("rst reqReady", 32'(reqReady), 32'd0);
      chk("rst respValid", 32'(respValid), 32'd0);
      chk("rst respErr", 32'(respErr), 32'd0);
      chk("rst respRdata", respRdata, 32'd0);
      chk("rst memWe", 32'(memWe), 32'd0);
      chk("rst memAddr", memAddr, 32'd0);
      chk("rst memDin", memDin, 32'd0);
      chk("rst memOp", 32'(memOp), 32'd2);

      // Continuous contention from reset: 0,1,0,1 every 3 cycles.
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 12; k++) begin
         logic [1:0] exp_rdy, exp_rv;
         exp_rdy = (k % 3 == 0) ? (((k / 3) % 2) ? 2'b10 : 2'b01) : 2'b00;
         exp_rv  = (k % 3 == 2) ? (((k / 3) % 2) ? 2'b10 : 2'b01) : 2'b00;
         #1;
         chk($sformatf("rr k%0d reqReady", k), 32'(reqReady), 32'(exp_rdy));
         chk($sformatf("rr k%0d respValid", k), 32'(respValid), 32'(exp_rv));
         @(negedge clk);
      end
      reqValid = 2'b00;
      @(negedge clk);
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

      // Reset during ACCESS of a port-0 store.
      reqAddr0 = 32'h40; reqWdata0 = 32'h11; reqOp0 = 3'd0; reqWe = 2'b01;
      reqValid = 2'b01;
      #1 chk("abort reqReady", 32'(reqReady), 32'd1);
      @(negedge clk);
      reqValid = 2'b00;
      #1 chk("abort access memWe", 32'(memWe), 32'd1);
      rstn = 1'b0;
      #1 chk("abort memWe async", 32'(memWe), 32'd0);
      chk("abort respValid async", 32'(respValid), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("abort post k%0d respValid", k), 32'(respValid), 32'd0);
         chk($sformatf("abort post k%0d memWe", k), 32'(memWe), 32'd0);
         @(negedge clk);
      end
      reqAddr0 = 32'h10; reqOp0 = 3'd2; reqAddr1 = 32'h20; reqOp1 = 3'd2; reqWe = 2'b00;
      reqValid = 2'b11;
      #1 chk("abort next grant", 32'(reqReady), 32'd1);
      @(negedge clk);
      reqValid = 2'b00;
      @(negedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
